// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue-control slice: opcodes, ALU width and
// the issue FSM state encoding.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 4;

   localparam logic [1:0] SEL_AND = 2'b00;
   localparam logic [1:0] SEL_OR  = 2'b01;
   localparam logic [1:0] SEL_XOR = 2'b10;
   localparam logic [1:0] SEL_ADD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and result handshake channels of alu_issue_ctrl.
// master = command producer / result consumer, slave = the issue stage.
interface alu_issue_ctrl_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [1:0]       cmd_sel;
   logic             cmd_acc;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;
   logic             res_zero;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_acc, res_ready,
      input  cmd_ready, res_valid, res_data, res_carry, res_zero
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_acc, res_ready,
      output cmd_ready, res_valid, res_data, res_carry, res_zero
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// Read data is the current head entry; no write-to-read bypass.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 2 * ALU_WIDTH + 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset since pointers/count gate reads.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-control stage around the 4-bit combinational ALU: buffers commands,
// issues one at a time from registered operands, registers the result with
// carry/zero flags and keeps an accumulator usable as operand a.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   alu_issue_ctrl_if.slave     bus,
   input  logic                acc_clr,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   output logic [1:0]          alu_sel,
   input  logic [WIDTH-1:0]    alu_out,
   input  logic                alu_carry,
   output logic                busy
);

   localparam int unsigned EW = 2 * WIDTH + 3;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t           state;
   state_t           state_n;
   logic             pop;

   logic [EW-1:0]    fifo_din;
   logic [EW-1:0]    fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;

   logic             e_acc;
   logic [1:0]       e_sel;
   logic [WIDTH-1:0] e_a;
   logic [WIDTH-1:0] e_b;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       op_sel;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] res_data_q;
   logic             res_carry_q;
   logic             res_zero_q;

   // Entry layout: {acc, sel, a, b}
   assign fifo_din = {bus.cmd_acc, bus.cmd_sel, bus.cmd_a, bus.cmd_b};
   assign {e_acc, e_sel, e_a, e_b} = fifo_dout;

   alu_cmd_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cmd_valid),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next-state and pop decision; RESP can pop directly for back-to-back issue.
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = EXEC;
            end
         end
         EXEC: state_n = RESP;
         RESP: begin
            if (bus.res_ready) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_n = EXEC;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Operand registers loaded from the FIFO head on every pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= '0;
      end else if (pop) begin
         op_a   <= e_acc ? acc : e_a;
         op_b   <= e_b;
         op_sel <= e_sel;
      end
   end

   // Result capture during the single EXEC cycle; held through RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_zero_q  <= 1'b0;
      end else if (state == EXEC) begin
         res_data_q  <= alu_out;
         res_carry_q <= (op_sel == SEL_ADD) ? alu_carry : 1'b0;
         res_zero_q  <= (alu_out == '0);
      end
   end

   // Accumulator; a clear pulse wins over the EXEC update.
   always_ff @(posedge clk) begin
      if (rst)                 acc <= '0;
      else if (acc_clr)        acc <= '0;
      else if (state == EXEC)  acc <= alu_out;
   end

   assign alu_a         = op_a;
   assign alu_b         = op_b;
   assign alu_sel       = op_sel;
   assign bus.cmd_ready = !fifo_full;
   assign bus.res_valid = (state == RESP);
   assign bus.res_data  = res_data_q;
   assign bus.res_carry = res_carry_q;
   assign bus.res_zero  = res_zero_q;
   assign busy          = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_issue_ctrl;

   logic       clk;
   logic       rst;
   logic       acc_clr;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_sel;
   logic [3:0] alu_out;
   logic       alu_carry;
   logic       busy;
   logic       force_c;
   logic [4:0] sum;

   int n_vec;
   int n_err;

   alu_issue_ctrl_if #(.WIDTH(4)) bus ();

   alu_issue_ctrl #(
      .WIDTH (4),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .acc_clr   (acc_clr),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU; force_c drives a spurious carry on the logic ops.
   always_comb begin
      sum = {1'b0, alu_a} + {1'b0, alu_b};
      case (alu_sel)
         2'b00:   {alu_carry, alu_out} = {force_c, alu_a & alu_b};
         2'b01:   {alu_carry, alu_out} = {force_c, alu_a | alu_b};
         2'b10:   {alu_carry, alu_out} = {force_c, alu_a ^ alu_b};
         default: {alu_carry, alu_out} = sum;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One command through an otherwise idle stage with res_ready held high.
   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] sel, input logic use_acc, input logic clr_exec,
                         input logic [3:0] exp_a, input logic [3:0] exp_d,
                         input logic exp_c, input logic exp_z);
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_sel   = sel;
      bus.cmd_acc   = use_acc;
      tick();
      bus.cmd_valid = 1'b0;
      check({tag, ".acc_valid"}, bus.res_valid, 1'b0);
      check({tag, ".acc_busy"}, busy, 1'b1);
      tick();
      check({tag, ".alu_a"}, alu_a, exp_a);
      check({tag, ".alu_b"}, alu_b, b);
      check({tag, ".alu_sel"}, alu_sel, sel);
      check({tag, ".exec_valid"}, bus.res_valid, 1'b0);
      acc_clr = clr_exec;
      tick();
      acc_clr = 1'b0;
      check({tag, ".valid"}, bus.res_valid, 1'b1);
      check({tag, ".data"}, bus.res_data, exp_d);
      check({tag, ".carry"}, bus.res_carry, exp_c);
      check({tag, ".zero"}, bus.res_zero, exp_z);
      tick();
      check({tag, ".done_valid"}, bus.res_valid, 1'b0);
   endtask

   logic [3:0] bp_a   [6] = '{4'h1, 4'h3, 4'hF, 4'h6, 4'h8, 4'h7};
   logic [3:0] bp_b   [6] = '{4'h1, 4'h4, 4'h5, 4'hC, 4'h9, 4'h7};
   logic [1:0] bp_sel [6] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11};
   logic [3:0] bp_res [5] = '{4'h2, 4'h7, 4'hA, 4'h4, 4'h1};
   logic       bp_cy  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      n_vec         = 0;
      n_err         = 0;
      force_c       = 1'b0;
      rst           = 1'b1;
      acc_clr       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_sel   = '0;
      bus.cmd_acc   = 1'b0;
      bus.res_ready = 1'b1;
      tick();
      tick();
      check("rst.cmd_ready", bus.cmd_ready, 1'b1);
      check("rst.res_valid", bus.res_valid, 1'b0);
      check("rst.res_data", bus.res_data, 4'h0);
      check("rst.res_carry", bus.res_carry, 1'b0);
      check("rst.res_zero", bus.res_zero, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.alu", {alu_a, alu_b, alu_sel}, 10'h0);
      rst = 1'b0;
      tick();

      run_op("add", 4'h3, 4'h1, 2'b11, 1'b0, 1'b0, 4'h3, 4'h4, 1'b0, 1'b0);
      run_op("add_wrap", 4'hF, 4'h1, 2'b11, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b1);
      run_op("and", 4'h4, 4'h2, 2'b00, 1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b1);
      run_op("or", 4'hC, 4'hA, 2'b01, 1'b0, 1'b0, 4'hC, 4'hE, 1'b0, 1'b0);
      force_c = 1'b1;
      run_op("xor_fc", 4'hC, 4'hA, 2'b10, 1'b0, 1'b0, 4'hC, 4'h6, 1'b0, 1'b0);
      force_c = 1'b0;
      // acc = 6; operand a field must be ignored
      run_op("acc_add", 4'hF, 4'h3, 2'b11, 1'b1, 1'b0, 4'h6, 4'h9, 1'b0, 1'b0);
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      run_op("acc_or", 4'hF, 4'h5, 2'b01, 1'b1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0);
      // clear during EXEC: result still reported, accumulator ends at 0
      run_op("clr_exec", 4'h2, 4'h3, 2'b11, 1'b0, 1'b1, 4'h2, 4'h5, 1'b0, 1'b0);
      run_op("acc_after_clr", 4'hF, 4'h0, 2'b01, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

      // Backpressure: six back-to-back pushes with the consumer stalled
      bus.res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_a     = bp_a[i];
         bus.cmd_b     = bp_b[i];
         bus.cmd_sel   = bp_sel[i];
         bus.cmd_acc   = 1'b0;
         check($sformatf("bp.cmd_ready%0d", i), bus.cmd_ready, (i < 5) ? 1'b1 : 1'b0);
         tick();
      end
      bus.cmd_valid = 1'b0;
      check("bp.full", bus.cmd_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp.stall_valid%0d", i), bus.res_valid, 1'b1);
         check($sformatf("bp.stall_data%0d", i), bus.res_data, 4'h2);
         tick();
      end
      bus.res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp.res_valid%0d", i), bus.res_valid, 1'b1);
         check($sformatf("bp.res_data%0d", i), bus.res_data, bp_res[i]);
         check($sformatf("bp.res_carry%0d", i), bus.res_carry, bp_cy[i]);
         tick();
         if (i < 4) begin
            check($sformatf("bp.gap%0d", i), bus.res_valid, 1'b0);
            tick();
         end
      end
      check("bp.end_valid", bus.res_valid, 1'b0);
      check("bp.end_busy", busy, 1'b0);
      check("bp.end_ready", bus.cmd_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp.no_sixth%0d", i), bus.res_valid, 1'b0);
      end

      // Reset in EXEC with three entries queued
      bus.res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_a     = 4'h1;
         bus.cmd_b     = 4'h1;
         bus.cmd_sel   = 2'b11;
         bus.cmd_acc   = 1'b0;
         tick();
      end
      bus.res_ready = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      check("rmid.busy", busy, 1'b1);
      check("rmid.exec_valid", bus.res_valid, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rmid.res_valid", bus.res_valid, 1'b0);
      check("rmid.cmd_ready", bus.cmd_ready, 1'b1);
      check("rmid.busy_after", busy, 1'b0);
      check("rmid.alu", {alu_a, alu_b, alu_sel}, 10'h0);
      check("rmid.res_data", bus.res_data, 4'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("rmid.stale%0d", i), bus.res_valid, 1'b0);
         check($sformatf("rmid.idle%0d", i), busy, 1'b0);
      end
      run_op("rmid_acc", 4'hF, 4'h0, 2'b01, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
